// File: rtl/piton_dcr_fifo.sv
// ============================================================================
// Module   : piton_dcr_fifo
// Purpose  : DCR write buffer between core control and Vortex, with
//            occupancy, sticky overflow flag and optional ready synchronizer
//            (enable with macro PITON_DCR_FIFO_RDY_SYNC_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module piton_dcr_fifo #(
    parameter int VX_DCR_ADDR_WIDTH = 8,
    parameter int VX_DCR_DATA_WIDTH = 32,
    parameter int DEPTH_LOG2        = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         buffer_wr_valid,
    input  logic [VX_DCR_ADDR_WIDTH-1:0] buffer_wr_addr,
    input  logic [VX_DCR_DATA_WIDTH-1:0] buffer_wr_data,
    output logic                         buffer_wr_ready,
    output logic                         buffer_full,
    output logic                         buffer_dcr_wr_valid,
    output logic [VX_DCR_ADDR_WIDTH-1:0] buffer_dcr_wr_addr,
    output logic [VX_DCR_DATA_WIDTH-1:0] buffer_dcr_wr_data,
    input  logic                         vx_buffer_rdy,
    input  logic                         flush,
    output logic [DEPTH_LOG2:0]          occupancy,
    output logic                         overflow_err,
    input  logic                         err_clr
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_PW    = DEPTH_LOG2 + 1;

    logic [c_PW-1:0]              r_wr_ptr;
    logic [c_PW-1:0]              r_rd_ptr;
    logic [VX_DCR_ADDR_WIDTH-1:0] r_addr_mem [c_DEPTH];
    logic [VX_DCR_DATA_WIDTH-1:0] r_data_mem [c_DEPTH];
    logic                         r_overflow;

    logic w_empty;
    logic w_full;
    logic w_rdy_eff;
    logic w_push;
    logic w_pop;
    logic w_drop;

`ifdef PITON_DCR_FIFO_RDY_SYNC_EN
    logic r_rdy_meta;
    logic r_rdy_sync;

    // Vortex ready may come from another timing domain; two flops before use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_meta <= 1'b0;
            r_rdy_sync <= 1'b0;
        end else begin
            r_rdy_meta <= vx_buffer_rdy;
            r_rdy_sync <= r_rdy_meta;
        end
    end

    assign w_rdy_eff = r_rdy_sync;
`else
    assign w_rdy_eff = vx_buffer_rdy;
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                     (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);

    // Full comes from registered pointers only, so a same-cycle pop never frees a slot.
    assign w_push = buffer_wr_valid && !w_full && !flush;
    assign w_drop = buffer_wr_valid &&  w_full && !flush;
    assign w_pop  = buffer_dcr_wr_valid && vx_buffer_rdy && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_addr_mem[i] <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_addr_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= buffer_wr_addr;
            r_data_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= buffer_wr_data;
        end
    end

    // A fresh overflow outranks a clear request arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (err_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign buffer_full         = w_full;
    assign buffer_wr_ready     = !w_full;
    assign buffer_dcr_wr_valid = !w_empty && w_rdy_eff;
    assign buffer_dcr_wr_addr  = r_addr_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign buffer_dcr_wr_data  = r_data_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign occupancy           = r_wr_ptr - r_rd_ptr;
    assign overflow_err        = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_piton_dcr_fifo.sv
// ============================================================================
// Module   : tb_piton_dcr_fifo
// Purpose  : Scoreboard bench for piton_dcr_fifo (DEPTH_LOG2 = 3).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_piton_dcr_fifo;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DL    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          buffer_wr_valid;
    logic [AW-1:0] buffer_wr_addr;
    logic [DW-1:0] buffer_wr_data;
    logic          buffer_wr_ready;
    logic          buffer_full;
    logic          buffer_dcr_wr_valid;
    logic [AW-1:0] buffer_dcr_wr_addr;
    logic [DW-1:0] buffer_dcr_wr_data;
    logic          vx_buffer_rdy;
    logic          flush;
    logic [DL:0]   occupancy;
    logic          overflow_err;
    logic          err_clr;

    piton_dcr_fifo #(
        .VX_DCR_ADDR_WIDTH (AW),
        .VX_DCR_DATA_WIDTH (DW),
        .DEPTH_LOG2        (DL)
    ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .buffer_wr_valid     (buffer_wr_valid),
        .buffer_wr_addr      (buffer_wr_addr),
        .buffer_wr_data      (buffer_wr_data),
        .buffer_wr_ready     (buffer_wr_ready),
        .buffer_full         (buffer_full),
        .buffer_dcr_wr_valid (buffer_dcr_wr_valid),
        .buffer_dcr_wr_addr  (buffer_dcr_wr_addr),
        .buffer_dcr_wr_data  (buffer_dcr_wr_data),
        .vx_buffer_rdy       (vx_buffer_rdy),
        .flush               (flush),
        .occupancy           (occupancy),
        .overflow_err        (overflow_err),
        .err_clr             (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic ovf_m  = 1'b0;
    logic mon_en = 1'b0;
    logic rd1, rd2;
    logic rdy_eff_m;

    // Ready as the FIFO sees it: two cycles late in the synchronized build.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1 <= 1'b0;
            rd2 <= 1'b0;
        end else begin
            rd1 <= vx_buffer_rdy;
            rd2 <= rd1;
        end
    end

`ifdef PITON_DCR_FIFO_RDY_SYNC_EN
    always_comb rdy_eff_m = rd2;
`else
    always_comb rdy_eff_m = vx_buffer_rdy;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT hands an entry to Vortex, it must be the queue head.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && mon_en) begin
            chk("out_valid", 64'(buffer_dcr_wr_valid), 64'((exp_q.size() > 0) && rdy_eff_m));
            if (buffer_dcr_wr_valid && vx_buffer_rdy && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty: got data 0x%0h expected no entry", buffer_dcr_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_addr", 64'(buffer_dcr_wr_addr), 64'(e.a));
                    chk("out_data", 64'(buffer_dcr_wr_data), 64'(e.d));
                end
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic wv, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic rdy, input logic fl, input logic ec);
        int sz0;
        buffer_wr_valid = wv;
        buffer_wr_addr  = a;
        buffer_wr_data  = d;
        vx_buffer_rdy   = rdy;
        flush           = fl;
        err_clr         = ec;
        sz0 = exp_q.size();
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (wv && sz0 < DEPTH) exp_q.push_back({a, d});
        if (wv && sz0 == DEPTH && !fl) ovf_m = 1'b1;
        else if (ec) ovf_m = 1'b0;
        #1;
        chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
        chk("full", 64'(buffer_full), 64'(exp_q.size() == DEPTH));
        chk("wr_ready", 64'(buffer_wr_ready), 64'(exp_q.size() != DEPTH));
        chk("overflow", 64'(overflow_err), 64'(ovf_m));
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(buffer_dcr_wr_valid), 64'd0);
        chk({tag, "_addr"},  64'(buffer_dcr_wr_addr),  64'd0);
        chk({tag, "_data"},  64'(buffer_dcr_wr_data),  64'd0);
        chk({tag, "_occ"},   64'(occupancy),           64'd0);
        chk({tag, "_full"},  64'(buffer_full),         64'd0);
        chk({tag, "_ready"}, 64'(buffer_wr_ready),     64'd1);
        chk({tag, "_ovf"},   64'(overflow_err),        64'd0);
    endtask

    initial begin
        rst = 1'b1;
        buffer_wr_valid = 1'b0;
        buffer_wr_addr  = '0;
        buffer_wr_data  = '0;
        vx_buffer_rdy   = 1'b0;
        flush           = 1'b0;
        err_clr         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_vals("rst");
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single entry round trip
        cycle(1'b1, 8'h10, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
        chk("single_occ", 64'(occupancy), 64'd1);
        idle(1'b1, 4);
        chk("single_drained", 64'(occupancy), 64'd0);

        // Nine pushes into an eight-entry FIFO with the consumer stalled
        idle(1'b0, 3);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, AW'(i), DW'(i), 1'b0, 1'b0, 1'b0);
            if (i == 7) begin
                chk("fill_full", 64'(buffer_full), 64'd1);
                chk("fill_occ8", 64'(occupancy), 64'd8);
            end
        end
        chk("fill_ovf", 64'(overflow_err), 64'd1);
        idle(1'b1, 12);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("errclr", 64'(overflow_err), 64'd0);

        // Push at full while popping: the push is still rejected
        idle(1'b0, 3);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, AW'(8'h40 + i), DW'(32'h1000 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        chk("pushpop_full_ovf", 64'(overflow_err), 64'd1);
`ifndef PITON_DCR_FIFO_RDY_SYNC_EN
        chk("pushpop_full_occ", 64'(occupancy), 64'd7);
`endif
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("pushpop_errclr", 64'(overflow_err), 64'd0);
        idle(1'b1, 12);

        // Streaming at occupancy 3, wrapping the pointers
        idle(1'b0, 3);
        for (int i = 0; i < 3; i++) cycle(1'b1, AW'(8'h80 + i), DW'(32'h200 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, AW'(8'h90 + i), DW'(32'h300 + i), 1'b1, 1'b0, 1'b0);
`ifndef PITON_DCR_FIFO_RDY_SYNC_EN
            chk("stream_occ3", 64'(occupancy), 64'd3);
`endif
        end
        idle(1'b1, 12);

        // Flush with a concurrent push discards everything
        idle(1'b0, 3);
        for (int i = 0; i < 5; i++) cycle(1'b1, AW'(8'hA0 + i), DW'(32'h400 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 32'h77777777, 1'b0, 1'b1, 1'b0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(buffer_dcr_wr_valid), 64'd0);
        idle(1'b1, 5);

        // Asynchronous reset with four queued entries and ready high
        idle(1'b0, 3);
        for (int i = 0; i < 4; i++) cycle(1'b1, AW'(8'hB0 + i), DW'(32'h500 + i), 1'b0, 1'b0, 1'b0);
        vx_buffer_rdy = 1'b1;
        #1;
        chk("prerst_valid", 64'(buffer_dcr_wr_valid), 64'(rdy_eff_m));
        rst = 1'b1;
        #1;
        reset_vals("async_rst");
        exp_q.delete();
        ovf_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic: mostly-stalled phase, then mostly-ready phase
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0),
                  AW'($urandom), DW'($urandom),
                  (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 19) == 0));
        end
        idle(1'b1, 12);
        chk("final_occ", 64'(occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/piton_dcr_fifo.md
PITON_DCR_FIFO -- requirements
Module: piton_dcr_fifo

Interface
REQ-001 Parameter VX_DCR_ADDR_WIDTH, default 8, is the DCR address width (AW).
REQ-002 Parameter VX_DCR_DATA_WIDTH, default 32, is the DCR data width (DW).
REQ-003 Parameter DEPTH_LOG2, default 3, sets the entry count to 2^DEPTH_LOG2, with a legal range of 1..8.
REQ-004 Port clk, input, 1 bit, is the single clock; all state SHALL be on posedge clk.
REQ-005 Port rst, input, 1 bit, is the reset; it SHALL be asynchronous and active-high.
REQ-006 Port buffer_wr_valid, input, 1 bit, is the write request from core control.
REQ-007 Port buffer_wr_addr, input, AW bits, is the DCR address to enqueue.
REQ-008 Port buffer_wr_data, input, DW bits, is the DCR data to enqueue.
REQ-009 Port buffer_wr_ready, output, 1 bit, SHALL equal ~buffer_full.
REQ-010 Port buffer_full, output, 1 bit, indicates the FIFO holds 2^DEPTH_LOG2 entries.
REQ-011 Port buffer_dcr_wr_valid, output, 1 bit, is the head-entry valid toward Vortex.
REQ-012 Port buffer_dcr_wr_addr, output, AW bits, is the head-entry address.
REQ-013 Port buffer_dcr_wr_data, output, DW bits, is the head-entry data.
REQ-014 Port vx_buffer_rdy, input, 1 bit, is the Vortex-side ready.
REQ-015 Port flush, input, 1 bit, is a synchronous FIFO clear.
REQ-016 Port occupancy, output, DEPTH_LOG2+1 bits, is the current entry count.
REQ-017 Port overflow_err, output, 1 bit, is a sticky flag for a dropped write.
REQ-018 Port err_clr, input, 1 bit, clears overflow_err.

Function
REQ-019 Read and write pointers SHALL each be DEPTH_LOG2+1 bits, increment by 1 per operation, and wrap modulo 2^(DEPTH_LOG2+1).
REQ-020 Empty SHALL be asserted when the pointers are equal.
REQ-021 Full SHALL be asserted when the pointers' low DEPTH_LOG2 bits are equal and their MSBs differ.
REQ-022 occupancy SHALL equal (wr_ptr - rd_ptr) mod 2^(DEPTH_LOG2+1), registered-state derived, with values 0..2^DEPTH_LOG2.
REQ-023 A push SHALL occur iff buffer_wr_valid && ~buffer_full && ~flush.
- On a push, addr/data are written at wr_ptr[DEPTH_LOG2-1:0].
REQ-024 buffer_wr_valid asserted while buffer_full (and flush low) SHALL drop the write, leave the pointers unchanged, and set overflow_err on the next edge.
REQ-025 buffer_dcr_wr_valid SHALL equal ~empty && rdy_eff, where rdy_eff is defined in Configuration.
REQ-026 A pop SHALL occur iff buffer_dcr_wr_valid && vx_buffer_rdy && ~flush.
REQ-027 buffer_dcr_wr_addr and buffer_dcr_wr_data SHALL present storage at rd_ptr[DEPTH_LOG2-1:0] combinationally.
- Addr/data SHALL be held stable while valid is high and no pop occurs.
REQ-028 Latency: an entry pushed at edge N SHALL be presentable at the outputs from cycle N+1 (no bypass).
REQ-029 Full is evaluated from registered pointers, so a push at full SHALL be rejected even when a pop occurs in the same cycle.
REQ-030 Push and pop in the same cycle with 0 < occupancy < 2^DEPTH_LOG2 SHALL leave occupancy unchanged.
REQ-031 flush SHALL zero both pointers on the next edge, taking precedence over any push/pop in that cycle.
- flush SHALL leave storage and overflow_err unchanged.
REQ-032 err_clr SHALL clear overflow_err on the next edge; a new overflow in the same cycle SHALL win, leaving the flag set.

Reset
REQ-033 On rst, the following SHALL be cleared asynchronously:
- pointers, all storage entries, and synchronizer flops → 0;
- buffer_dcr_wr_valid = 0, buffer_dcr_wr_addr = 0, buffer_dcr_wr_data = 0;
- occupancy = 0, buffer_full = 0, buffer_wr_ready = 1, overflow_err = 0.
REQ-034 Reset asserted mid-transfer SHALL discard all queued entries with no partial pop visible.

Configuration
REQ-035 With macro PITON_DCR_FIFO_RDY_SYNC_EN defined:
- vx_buffer_rdy passes through a two-flop synchronizer, and rdy_eff is the second flop;
- valid rises at least 2 cycles after rdy rises.
REQ-036 With PITON_DCR_FIFO_RDY_SYNC_EN undefined, rdy_eff SHALL be vx_buffer_rdy directly.
- No synchronizer flops exist.
- Pop condition REQ-026 is unchanged in both builds.

Verification (DEPTH_LOG2=3)
REQ-037 Reset, then push (0x10,0xA5A5A5A5) with rdy=1:
- occupancy = 1 after 1 edge;
- addr=0x10, data=0xA5A5A5A5 with valid=1 next cycle (2 cycles later with sync build);
- popped, occupancy returns to 0.
REQ-038 rdy=0, 9 consecutive pushes of data 0..8:
- full=1 and occupancy=8 after the 8th;
- the 9th is dropped and overflow_err=1;
- draining yields data 0..7 in order.
REQ-039 Fill 8 entries, then push and pop in the same cycle:
- push rejected, occupancy=7, overflow_err=1;
- err_clr then clears the flag.
REQ-040 Stream 20 entries with continuous push/pop at occupancy 3:
- pointers wrap past 15;
- data order preserved, no loss, occupancy stays 3.
REQ-041 With occupancy=5, assert flush together with a push:
- next cycle occupancy=0, valid=0;
- the pushed entry is never output.
REQ-042 Assert rst with occupancy=4 and valid=1:
- all outputs immediately return to reset values without waiting for clk.
